// File: rtl/i2c_txn_arbiter_if.sv
// Bundle of client request/response ports and the shared I2C master handshake.
// The master modport is the arbiter's view; slave is the clients plus the I2C master.
interface i2c_txn_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [7*NUM_REQ-1:0] req_addr;
  logic [NUM_REQ-1:0]   req_rw;
  logic [8*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic                 err;
  logic [7:0]           rdata;
  logic                 m_start;
  logic [6:0]           m_addr;
  logic                 m_rw;
  logic [7:0]           m_wdata;
  logic                 m_abort;
  logic                 m_busy;
  logic                 m_done;
  logic                 m_nack;
  logic [7:0]           m_rdata;

  modport master (
    input  req, req_addr, req_rw, req_wdata, m_busy, m_done, m_nack, m_rdata,
    output gnt, done, err, rdata, m_start, m_addr, m_rw, m_wdata, m_abort
  );

  modport slave (
    output req, req_addr, req_rw, req_wdata, m_busy, m_done, m_nack, m_rdata,
    input  gnt, done, err, rdata, m_start, m_addr, m_rw, m_wdata, m_abort
  );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin sequencer sharing one I2C master among NUM_REQ clients, with a
// bus-free gap between transactions and a watchdog abort on a hung master.
module i2c_txn_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned BUS_FREE    = 10,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned TO_W        = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  i2c_txn_arbiter_if.master bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned GAP_W = $clog2(BUS_FREE + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_rr;
  logic [IDX_W-1:0]   r_owner;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic               r_err;
  logic [7:0]         r_rdata;
  logic               r_start;
  logic               r_abort;
  logic [6:0]         r_addr;
  logic               r_rw;
  logic [7:0]         r_wdata;
  logic [TO_W-1:0]    r_wd;
  logic [GAP_W-1:0]   r_gap;

  logic               w_found;
  logic [IDX_W-1:0]   w_pick;
  logic [IDX_W-1:0]   w_rr_next;

  // First requesting client at or after the rr pointer, wrapping at NUM_REQ-1.
  always_comb begin
    int unsigned j;
    w_found = 1'b0;
    w_pick  = '0;
    j       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = 32'(r_rr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_found && bus.req[IDX_W'(j)]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(j);
      end
    end
  end

  assign w_rr_next = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_rr    <= '0;
      r_owner <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_start <= 1'b0;
      r_abort <= 1'b0;
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_wdata <= '0;
      r_wd    <= '0;
      r_gap   <= '0;
    end else begin
      r_start <= 1'b0;
      r_abort <= 1'b0;
      r_done  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found && !bus.m_busy) begin
            r_owner <= w_pick;
            r_gnt   <= NUM_REQ'(1) << w_pick;
            r_addr  <= bus.req_addr[32'(w_pick)*7 +: 7];
            r_rw    <= bus.req_rw[w_pick];
            r_wdata <= bus.req_wdata[32'(w_pick)*8 +: 8];
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_start <= 1'b1;
          r_wd    <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A master completion on the expiry cycle takes priority over the abort.
          if (bus.m_done) begin
            r_done  <= r_gnt;
            r_err   <= bus.m_nack;
            if (r_rw && !bus.m_nack) r_rdata <= bus.m_rdata;
            r_gap   <= '0;
            r_state <= ST_GAP;
          end else if (r_wd == TO_W'(TIMEOUT_CYC - 1)) begin
            r_abort <= 1'b1;
            r_done  <= r_gnt;
            r_err   <= 1'b1;
            r_gap   <= '0;
            r_state <= ST_GAP;
          end else begin
            r_wd <= r_wd + TO_W'(1);
          end
        end
        ST_GAP: begin
          if (r_gap == GAP_W'(BUS_FREE - 1)) begin
            r_gnt   <= '0;
            r_rr    <= w_rr_next;
            r_state <= ST_IDLE;
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.rdata   = r_rdata;
  assign bus.m_start = r_start;
  assign bus.m_addr  = r_addr;
  assign bus.m_rw    = r_rw;
  assign bus.m_wdata = r_wdata;
  assign bus.m_abort = r_abort;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed self-checking bench for i2c_txn_arbiter; the I2C master is played by
// the tasks below, which answer m_start with a scripted m_done.
module tb_i2c_txn_arbiter;

  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned BUS_FREE    = 10;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam int unsigned TO_W        = 5;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  i2c_txn_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  i2c_txn_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .BUS_FREE   (BUS_FREE),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_W       (TO_W)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.req       = '0;
    bus.req_addr  = '0;
    bus.req_rw    = '0;
    bus.req_wdata = '0;
    bus.m_busy    = 1'b0;
    bus.m_done    = 1'b0;
    bus.m_nack    = 1'b0;
    bus.m_rdata   = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_start(input int limit, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (bus.m_start) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    int n;
    n = 0;
    while (bus.gnt != '0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.gnt == '0);
  endtask

  // Waits lat negedges, then presents m_done for one cycle; returns on the
  // negedge where the arbiter's response is visible.
  task automatic pulse_done(input bit nack, input logic [7:0] rd, input int lat);
    repeat (lat) @(negedge clk);
    bus.m_done  = 1'b1;
    bus.m_nack  = nack;
    bus.m_rdata = rd;
    @(negedge clk);
    bus.m_done  = 1'b0;
    bus.m_nack  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.gnt !== 4'b0000 || bus.done !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_gnt_done: gnt=%b done=%b required 0000/0000", bus.gnt, bus.done);
    end
    n_checks++;
    if (bus.err !== 1'b0 || bus.rdata !== 8'h00 || bus.m_start !== 1'b0 || bus.m_abort !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: err=%b rdata=%h m_start=%b m_abort=%b required 0/00/0/0",
               bus.err, bus.rdata, bus.m_start, bus.m_abort);
    end
    n_checks++;
    if (bus.m_addr !== 7'h00 || bus.m_rw !== 1'b0 || bus.m_wdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_fields: m_addr=%h m_rw=%b m_wdata=%h required 00/0/00",
               bus.m_addr, bus.m_rw, bus.m_wdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    int n;
    bit ok;
    bus.req_addr[14 +: 7]  = 7'h50;
    bus.req_rw[2]          = 1'b0;
    bus.req_wdata[16 +: 8] = 8'hA5;
    bus.req[2]             = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.gnt !== 4'b0100 || bus.m_start !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant: gnt=%b m_start=%b required 0100/0", bus.gnt, bus.m_start);
    end
    @(negedge clk);
    n_checks++;
    if (bus.m_start !== 1'b1 || bus.m_addr !== 7'h50 || bus.m_wdata !== 8'hA5 || bus.m_rw !== 1'b0) begin
      n_fail++;
      $display("FAIL single_start: m_start=%b m_addr=%h m_wdata=%h m_rw=%b required 1/50/A5/0",
               bus.m_start, bus.m_addr, bus.m_wdata, bus.m_rw);
    end
    pulse_done(1'b0, 8'h00, 3);
    bus.req[2] = 1'b0;
    n_checks++;
    if (bus.done !== 4'b0100 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: done=%b err=%b required 0100/0", bus.done, bus.err);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 4'b0000 || bus.gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_done_pulse: done=%b gnt=%b required 0000/0100", bus.done, bus.gnt);
    end
    n = 1;
    while (bus.gnt != '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n != BUS_FREE || bus.gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_gap_len: gnt held %0d cycles after done, required %0d", n, BUS_FREE);
    end
    wait_start(5, n, ok);
    n_checks++;
    if (ok) begin
      n_fail++;
      $display("FAIL single_no_regrant: m_start seen with no request, required none");
    end
  endtask

  task automatic test_round_robin();
    int  n;
    bit  ok;
    int  ord[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      bus.req_addr[7*i +: 7]  = 7'(16 + i);
      bus.req_wdata[8*i +: 8] = 8'(128 + i);
    end
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_start(200, n, ok);
      n_checks++;
      if (!ok || bus.gnt !== 4'(1 << ord[k]) || bus.m_addr !== 7'(16 + ord[k])) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: started=%b gnt=%b m_addr=%h required 1/%b/%h",
                 k, ok, bus.gnt, bus.m_addr, 4'(1 << ord[k]), 7'(16 + ord[k]));
      end
      // One WAIT cycle + BUS_FREE gap + IDLE + ISSUE between consecutive starts.
      if (k > 0) begin
        n_checks++;
        if (n + 1 != int'(BUS_FREE) + 3) begin
          n_fail++;
          $display("FAIL rr_spacing[%0d]: %0d cycles between starts, required %0d",
                   k, n + 1, BUS_FREE + 3);
        end
      end
      pulse_done(1'b0, 8'h00, 0);
      if (k == 4) bus.req = 4'b0000;
    end
    wait_idle(100, ok);
  endtask

  task automatic test_read();
    int n;
    bit ok;
    bus.req_addr[7 +: 7] = 7'h21;
    bus.req_rw[1]        = 1'b1;
    bus.req[1]           = 1'b1;
    wait_start(20, n, ok);
    n_checks++;
    if (!ok || bus.m_rw !== 1'b1 || bus.gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL read_start: started=%b m_rw=%b gnt=%b required 1/1/0010", ok, bus.m_rw, bus.gnt);
    end
    pulse_done(1'b0, 8'h3C, 2);
    bus.req[1] = 1'b0;
    n_checks++;
    if (bus.rdata !== 8'h3C || bus.done !== 4'b0010 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL read_ok: rdata=%h done=%b err=%b required 3C/0010/0", bus.rdata, bus.done, bus.err);
    end
    wait_idle(100, ok);
    bus.req[1] = 1'b1;
    wait_start(20, n, ok);
    pulse_done(1'b1, 8'h77, 1);
    bus.req[1] = 1'b0;
    n_checks++;
    if (!ok || bus.rdata !== 8'h3C || bus.done !== 4'b0010 || bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL read_nack: started=%b rdata=%h done=%b err=%b required 1/3C/0010/1",
               ok, bus.rdata, bus.done, bus.err);
    end
    wait_idle(100, ok);
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    bus.req[3] = 1'b1;
    wait_start(20, n, ok);
    bus.req[3] = 1'b0;
    n = 0;
    while (!bus.m_abort && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!ok || n != int'(TIMEOUT_CYC)) begin
      n_fail++;
      $display("FAIL timeout_when: abort %0d cycles after start, required %0d", n, TIMEOUT_CYC);
    end
    n_checks++;
    if (bus.m_abort !== 1'b1 || bus.done !== 4'b1000 || bus.err !== 1'b1 || bus.rdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL timeout_resp: m_abort=%b done=%b err=%b rdata=%h required 1/1000/1/3C",
               bus.m_abort, bus.done, bus.err, bus.rdata);
    end
    @(negedge clk);
    n_checks++;
    if (bus.m_abort !== 1'b0 || bus.done !== 4'b0000) begin
      n_fail++;
      $display("FAIL timeout_pulse: m_abort=%b done=%b required 0/0000", bus.m_abort, bus.done);
    end
    wait_idle(100, ok);
    bus.req[0] = 1'b1;
    wait_start(40, n, ok);
    pulse_done(1'b0, 8'h00, int'(TIMEOUT_CYC) - 1);
    bus.req[0] = 1'b0;
    n_checks++;
    if (!ok || bus.m_abort !== 1'b0 || bus.done !== 4'b0001 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_tie: started=%b m_abort=%b done=%b err=%b required 1/0/0001/0",
               ok, bus.m_abort, bus.done, bus.err);
    end
    wait_idle(100, ok);
  endtask

  task automatic test_busy_block();
    int n;
    int bad;
    bit ok;
    bus.m_busy = 1'b1;
    bus.req[0] = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.gnt != '0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL busy_hold: gnt nonzero on %0d cycles while m_busy, required 0", bad);
    end
    bus.m_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL busy_release: gnt=%b required 0001", bus.gnt);
    end
    wait_start(20, n, ok);
    pulse_done(1'b0, 8'h00, 1);
    bus.req[0] = 1'b0;
    wait_idle(100, ok);
  endtask

  task automatic test_reset_in_wait();
    int n;
    bit ok;
    bus.req[2] = 1'b1;
    wait_start(20, n, ok);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (!ok || bus.gnt !== 4'b0000 || bus.m_start !== 1'b0 || bus.m_abort !== 1'b0 || bus.done !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_wait_async: started=%b gnt=%b m_start=%b m_abort=%b done=%b required 1/0000/0/0/0000",
               ok, bus.gnt, bus.m_start, bus.m_abort, bus.done);
    end
    bus.req_addr[0 +: 7] = 7'h6A;
    bus.req              = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_wait_regrant: gnt=%b required 0001", bus.gnt);
    end
    wait_start(20, n, ok);
    n_checks++;
    if (!ok || bus.m_addr !== 7'h6A) begin
      n_fail++;
      $display("FAIL rst_wait_start: started=%b m_addr=%h required 1/6A", ok, bus.m_addr);
    end
    pulse_done(1'b0, 8'h00, 1);
    bus.req = 4'b0000;
    wait_idle(100, ok);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_read();
    test_timeout();
    test_busy_block();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
